// File: rtl/waveform_capture_buffer_if.sv
// Bus bundle for the waveform capture buffer: acquisition controls and
// sample input from the trigger/ADC side, record readout toward the CPU.
// Handshake: there is no valid/ready pairing. sample_in is taken on every
// clock while capturing. rd_addr is sampled on every clock, and rd_data
// answers it one clock later. ready is a level that stays high while a
// frozen record is held.
interface waveform_capture_buffer_if #(
    parameter int DATA_W = 14
);
    logic [DATA_W-1:0] sample_in;
    logic              trig_in;
    logic              arm_en;
    logic              rearm;
    logic [15:0]       rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              ready;
    logic              busy;
    logic [15:0]       wave_num;
    logic [2:0]        dbg_state;

    // Driver side (CPU / trigger logic / testbench)
    modport master (
        output sample_in, trig_in, arm_en, rearm, rd_addr,
        input  rd_data, ready, busy, wave_num, dbg_state
    );

    // Capture buffer side
    modport slave (
        input  sample_in, trig_in, arm_en, rearm, rd_addr,
        output rd_data, ready, busy, wave_num, dbg_state
    );
endinterface

// File: rtl/waveform_capture_buffer.sv
// Pre-trigger ring buffer. It writes ADC samples continuously into a circular
// memory. A trigger rising edge freezes a DEPTH-sample record: PRE_TRIG samples
// come before the trigger, and the rest start at the trigger sample. The CPU
// reads the record by trigger-relative index.
module waveform_capture_buffer #(
    parameter int DEPTH    = 1000,
    parameter int PRE_TRIG = 100,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 14
) (
    input logic                    clk,
    input logic                    reset_n,
    waveform_capture_buffer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PREFILL = 3'd1,
        S_ARMED   = 3'd2,
        S_POST    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LP_LAST      = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LP_PRE       = ADDR_W'(PRE_TRIG);
    localparam logic [ADDR_W-1:0] LP_PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] LP_POST_LOAD = ADDR_W'(DEPTH - PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] LP_POST_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LP_DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LP_PRE_X     = (ADDR_W + 1)'(PRE_TRIG);
    localparam logic [15:0]       LP_DEPTH_16  = 16'(DEPTH);
    localparam bit                LP_NO_POST   = (DEPTH - PRE_TRIG == 1);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    state_t            r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_start_ptr;
    logic [ADDR_W-1:0] r_pre_cnt;
    logic [ADDR_W-1:0] r_post_cnt;
    logic              r_trig_prev;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_ready;
    logic              r_busy;
    logic [15:0]       r_wave_num;

    logic              w_trig_edge;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_start_ptr;
    logic [ADDR_W:0]   w_rd_sum;
    logic [ADDR_W-1:0] w_rd_idx;
    logic              w_rd_in_range;

    assign w_trig_edge = bus.trig_in & ~r_trig_prev;
    assign w_wr_en     = (r_state == S_PREFILL) || (r_state == S_ARMED) ||
                         (r_state == S_POST);

    // The trigger sample is written at wr_ptr, so the record starts PRE_TRIG entries earlier
    assign w_start_ptr = (r_wr_ptr >= LP_PRE) ? (r_wr_ptr - LP_PRE)
                       : ADDR_W'({1'b0, r_wr_ptr} + LP_DEPTH_X - LP_PRE_X);

    // Both operands are below DEPTH when in range, so one conditional subtract wraps the sum
    assign w_rd_sum      = {1'b0, r_start_ptr} + bus.rd_addr[ADDR_W:0];
    assign w_rd_idx      = (w_rd_sum >= LP_DEPTH_X) ? ADDR_W'(w_rd_sum - LP_DEPTH_X)
                                                    : w_rd_sum[ADDR_W-1:0];
    assign w_rd_in_range = (bus.rd_addr < LP_DEPTH_16);

    // Sample memory write port (no reset, RAM-inferable)
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= bus.sample_in;
        end
    end

    // Registered read port; out-of-range indices return zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_in_range ? r_mem[w_rd_idx] : '0;
        end
    end

    // Write pointer advances with every stored sample and wraps at DEPTH
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
        end else if (w_wr_en) begin
            r_wr_ptr <= (r_wr_ptr == LP_LAST) ? '0 : r_wr_ptr + 1'b1;
        end
    end

    // Trigger history for rising-edge detection, tracked in every state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_trig_prev <= 1'b0;
        end else begin
            r_trig_prev <= bus.trig_in;
        end
    end

    // Capture control FSM with registered ready/busy/wave_num
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_pre_cnt   <= '0;
            r_post_cnt  <= '0;
            r_start_ptr <= '0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_wave_num  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.arm_en) begin
                        r_state   <= S_PREFILL;
                        r_pre_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                S_PREFILL: begin
                    if (!bus.arm_en) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_pre_cnt <= r_pre_cnt + 1'b1;
                        if (r_pre_cnt == LP_PRE_LAST) begin
                            r_state <= S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    if (!bus.arm_en) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_trig_edge) begin
                        r_start_ptr <= w_start_ptr;
                        r_post_cnt  <= LP_POST_LOAD;
                        if (LP_NO_POST) begin
                            r_state    <= S_DONE;
                            r_ready    <= 1'b1;
                            r_busy     <= 1'b0;
                            r_wave_num <= r_wave_num + 1'b1;
                        end else begin
                            r_state <= S_POST;
                        end
                    end
                end
                S_POST: begin
                    // The write where post_cnt counts down to zero completes the record
                    if (!bus.arm_en) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_post_cnt <= r_post_cnt - 1'b1;
                        if (r_post_cnt == LP_POST_ONE) begin
                            r_state    <= S_DONE;
                            r_ready    <= 1'b1;
                            r_busy     <= 1'b0;
                            r_wave_num <= r_wave_num + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (!bus.arm_en) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b0;
                    end else if (bus.rearm) begin
                        r_state   <= S_PREFILL;
                        r_pre_cnt <= '0;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_data   = r_rd_data;
    assign bus.ready     = r_ready;
    assign bus.busy      = r_busy;
    assign bus.wave_num  = r_wave_num;
    assign bus.dbg_state = r_state;

endmodule
